multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_pkg.sv | 49 ++++
 rtl/multicycle_control_alu_decoder.sv | 35 +++
 rtl/multicycle_control.sv | 138 +++++++++++++
 tb/tb_multicycle_control.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - shared states, opcodes, funct codes, ALUOp and ALU operation codes
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_NONE  = 2'b11;

  localparam logic [3:0] OPER_AND = 4'b0000;
  localparam logic [3:0] OPER_OR  = 4'b0001;
  localparam logic [3:0] OPER_ADD = 4'b0010;
  localparam logic [3:0] OPER_SUB = 4'b0110;
  localparam logic [3:0] OPER_SLT = 4'b0111;
  localparam logic [3:0] OPER_INV = 4'b1111;

  function automatic logic is_legal(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// rtl/multicycle_control_alu_decoder.sv - ALU control code from ALUOp and funct, zero-extended to OPER_W
module alu_decoder
  import multicycle_control_pkg::*;
#(
  parameter int OPER_W = 4
) (
  input  logic [1:0]        ALUOp,
  input  logic [5:0]        funct_field,
  output logic [OPER_W-1:0] operation
);

  logic [3:0] code;

  always_comb begin
    code = OPER_INV;
    case (ALUOp)
      ALUOP_ADD: code = OPER_ADD;
      ALUOP_SUB: code = OPER_SUB;
      ALUOP_FUNCT: begin
        case (funct_field)
          FN_ADD:  code = OPER_ADD;
          FN_SUB:  code = OPER_SUB;
          FN_AND:  code = OPER_AND;
          FN_OR:   code = OPER_OR;
          FN_SLT:  code = OPER_SLT;
          default: code = OPER_INV;
        endcase
      end
      default: code = OPER_INV;
    endcase
    operation      = '0;
    operation[3:0] = code;
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS-subset control FSM with optional memory handshake
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 0,
  parameter int OPER_W        = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        op_code,
  input  logic [5:0]        funct_field,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              PCWrite,
  output logic              PCWriteCond,
  output logic              pc_en,
  output logic              IorD,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              IRWrite,
  output logic              MemtoReg,
  output logic              RegDst,
  output logic              RegWrite,
  output logic              ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [1:0]        PCSrc,
  output logic [1:0]        ALUOp,
  output logic [OPER_W-1:0] operation,
  output logic [3:0]        state,
  output logic              illegal_op
);

  state_t state_q, state_d;
  logic   mem_done;

  assign mem_done = (MEM_HANDSHAKE == 0) || mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  if (mem_done) state_d = DECODE;
      DECODE: begin
        case (op_code)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDIEX;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: state_d = (op_code == OP_LW) ? MEMRD : ((op_code == OP_SW) ? MEMWR : FETCH);
      MEMRD:  if (mem_done) state_d = MEMWB;
      MEMWR:  if (mem_done) state_d = FETCH;
      EXEC:   state_d = ALUWB;
      ADDIEX: state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  // Fetch strobes are qualified by rst_n so the asynchronously forced FETCH never writes.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSrc       = 2'b00;
    ALUOp       = ALUOP_ADD;
    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        IRWrite = rst_n && mem_done;
        PCWrite = rst_n && mem_done;
        ALUSrcB = 2'b01;
      end
      DECODE: ALUSrcB = 2'b11;
      MEMADR, ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      ADDIWB: RegWrite = 1'b1;
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSrc       = 2'b01;
      end
      JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = 2'b10;
      end
      default: ;
    endcase
  end

  assign pc_en      = PCWrite | (PCWriteCond & zero);
  assign illegal_op = (state_q == DECODE) && !is_legal(op_code);
  assign state      = state_q;

  alu_decoder #(.OPER_W(OPER_W)) u_alu_decoder (
    .ALUOp       (ALUOp),
    .funct_field (funct_field),
    .operation   (operation)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;

  logic       clk = 1'b1;
  logic       rst_n = 1'b1;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic [5:0] op_code = 6'b000000;
  logic [5:0] funct_field = 6'b100010;

  always #5 clk = ~clk;

  logic       PCWrite, PCWriteCond, pc_en, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
  logic [1:0] ALUSrcB, PCSrc, ALUOp;
  logic [5:0] operation;
  logic [3:0] state;

  logic       b_pcw, b_pcwc, b_pcen, b_iord, b_mrd, b_mwr, b_irw;
  logic       b_m2r, b_rdst, b_rw, b_srca, b_ill;
  logic [1:0] b_srcb, b_pcsrc, b_aluop;
  logic [3:0] b_operation;
  logic [3:0] b_state;

  multicycle_control #(.MEM_HANDSHAKE(1), .OPER_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .op_code(op_code), .funct_field(funct_field),
    .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .pc_en(pc_en), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUOp(ALUOp),
    .operation(operation), .state(state), .illegal_op(illegal_op)
  );

  multicycle_control dut_b (
    .clk(clk), .rst_n(rst_n), .op_code(op_code), .funct_field(funct_field),
    .zero(zero), .mem_ready(mem_ready), .PCWrite(b_pcw), .PCWriteCond(b_pcwc),
    .pc_en(b_pcen), .IorD(b_iord), .MemRead(b_mrd), .MemWrite(b_mwr),
    .IRWrite(b_irw), .MemtoReg(b_m2r), .RegDst(b_rdst), .RegWrite(b_rw),
    .ALUSrcA(b_srca), .ALUSrcB(b_srcb), .PCSrc(b_pcsrc), .ALUOp(b_aluop),
    .operation(b_operation), .state(b_state), .illegal_op(b_ill)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcwc, pcen, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
    logic [1:0] srcb, pcsrc, aluop;
    logic [5:0] oper;
    logic       ill;
  } obs_t;

  typedef struct {
    logic mr;
    obs_t e;
  } item_t;

  item_t sb[$];
  int    total = 0;
  int    bad = 0;
  string cur = "init";

  function automatic obs_t observe();
    obs_t o;
    o.st = state; o.pcw = PCWrite; o.pcwc = PCWriteCond; o.pcen = pc_en;
    o.iord = IorD; o.mrd = MemRead; o.mwr = MemWrite; o.irw = IRWrite;
    o.m2r = MemtoReg; o.rdst = RegDst; o.rw = RegWrite; o.srca = ALUSrcA;
    o.srcb = ALUSrcB; o.pcsrc = PCSrc; o.aluop = ALUOp; o.oper = operation;
    o.ill = illegal_op;
    return o;
  endfunction

  function automatic logic [5:0] exp_oper(input logic [1:0] aop, input logic [5:0] fn);
    case (aop)
      2'b00: return 6'b000010;
      2'b01: return 6'b000110;
      2'b10: begin
        case (fn)
          6'b100000: return 6'b000010;
          6'b100010: return 6'b000110;
          6'b100100: return 6'b000000;
          6'b100101: return 6'b000001;
          6'b101010: return 6'b000111;
          default:   return 6'b001111;
        endcase
      end
      default: return 6'b001111;
    endcase
  endfunction

  function automatic obs_t exp_of(input int st, input logic rstn, input logic mr);
    obs_t e = '0;
    logic known;
    known = (op_code == 6'b000000) || (op_code == 6'b100011) || (op_code == 6'b101011) ||
            (op_code == 6'b000100) || (op_code == 6'b001000) || (op_code == 6'b000010);
    e.st = st[3:0];
    case (st)
      0:  begin e.mrd = 1; e.irw = rstn & mr; e.pcw = rstn & mr; e.srcb = 2'b01; end
      1:  begin e.srcb = 2'b11; e.ill = !known; end
      2, 10: begin e.srca = 1; e.srcb = 2'b10; end
      3:  begin e.mrd = 1; e.iord = 1; end
      4:  begin e.rw = 1; e.m2r = 1; end
      5:  begin e.mwr = 1; e.iord = 1; end
      6:  begin e.srca = 1; e.aluop = 2'b10; end
      7:  begin e.rw = 1; e.rdst = 1; end
      8:  begin e.srca = 1; e.aluop = 2'b01; e.pcwc = 1; e.pcsrc = 2'b01; end
      9:  begin e.pcw = 1; e.pcsrc = 2'b10; end
      11: e.rw = 1;
      default: ;
    endcase
    e.pcen = e.pcw | (e.pcwc & zero);
    e.oper = exp_oper(e.aluop, funct_field);
    return e;
  endfunction

  task automatic check(input obs_t e);
    obs_t o;
    o = observe();
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s/st%0d: observed=%h expected=%h", cur, e.st, o, e);
    end
  endtask

  task automatic check_b(input logic [3:0] st, input logic [3:0] op);
    total++;
    assert ({b_state, b_operation} === {st, op}) else begin
      bad++;
      $error("FAIL %s/oper4: observed=%h expected=%h", cur, {b_state, b_operation}, {st, op});
    end
  endtask

  task automatic push(input int st, input logic mr = 1'b1);
    item_t it;
    it.mr = mr;
    it.e  = exp_of(st, 1'b1, mr);
    sb.push_back(it);
  endtask

  task automatic drain();
    item_t it;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      mem_ready = it.mr;
      @(negedge clk);
      check(it.e);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    #1 cur = "reset"; check(exp_of(0, 1'b0, 1'b1));
    #1 rst_n = 1'b1;

    cur = "r_sub"; op_code = 6'b000000; funct_field = 6'b100010;
    push(0); push(1); push(6); push(7); drain();

    cur = "r_slt"; funct_field = 6'b101010;
    push(0); push(1); drain();
    check_b(4'd6, 4'b0111);
    push(6); push(7); drain();

    cur = "r_bad"; funct_field = 6'b000000;
    push(0); push(1); drain();
    check_b(4'd6, 4'b1111);
    push(6); push(7); drain();

    cur = "r_or"; funct_field = 6'b100101;
    push(0); push(1); push(6); push(7); drain();

    cur = "beq_t"; op_code = 6'b000100; zero = 1'b1;
    push(0); push(1); push(8); drain();
    cur = "beq_f"; zero = 1'b0;
    push(0); push(1); push(8); drain();

    cur = "j"; op_code = 6'b000010;
    push(0); push(1); push(9); drain();
    cur = "addi"; op_code = 6'b001000;
    push(0); push(1); push(10); push(11); drain();
    cur = "sw"; op_code = 6'b101011;
    push(0); push(1); push(2); push(5); drain();
    cur = "lw"; op_code = 6'b100011;
    push(0); push(1); push(2); push(3); push(4); drain();
    cur = "illegal"; op_code = 6'b111111;
    push(0); push(1); drain();

    cur = "rst_aluwb"; op_code = 6'b000000; funct_field = 6'b100000;
    push(0); push(1); push(6); drain();
    check(exp_of(7, 1'b1, 1'b1));
    rst_n = 1'b0;
    #1 check(exp_of(0, 1'b0, 1'b1));
    @(negedge clk);
    rst_n = 1'b1;
    #1 check(exp_of(0, 1'b1, 1'b1));
    @(posedge clk);
    #1;
    push(1); push(6); push(7); drain();

    cur = "lw_stall"; op_code = 6'b100011;
    push(0, 1'b0); push(0); push(1); push(2);
    push(3, 1'b0); push(3, 1'b0); push(3, 1'b0); push(3); push(4);
    drain();

    cur = "sw_hold_rst"; op_code = 6'b101011;
    push(0); push(1); push(2); push(5, 1'b0); drain();
    rst_n = 1'b0;
    #1 check(exp_of(0, 1'b0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    #1 check(exp_of(0, 1'b1, 1'b1));
    @(posedge clk);
    #1;
    push(1); push(2); push(5); push(0); drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
